// File: rtl/simd_sequencer.sv
// Streams DEPTH-element vector jobs through an external LANES-wide simdcore; job takes 2*ceil(len/LANES)+1 cycles.
// No backpressure: start/wr_en are only honoured in IDLE. Define SIMD_SEQ_FLAGS_EN to enable job-level flag accumulation.
module simd_sequencer #(
    parameter int LANES = 16,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [AW-1:0]         wr_addr,
    input  logic [31:0]           wr_data,
    input  logic                  start,
    input  logic [2:0]            cmd,
    input  logic [AW:0]           len,
    output logic                  busy,
    output logic                  done,
    output logic                  any_overflow,
    output logic                  all_zero,
    input  logic [AW-1:0]         rd_addr,
    output logic [31:0]           rd_data,
    output logic [2:0]            core_command,
    output logic [32*LANES-1:0]   core_opA,
    output logic [32*LANES-1:0]   core_opB,
    input  logic [32*LANES-1:0]   core_result,
    input  logic [LANES-1:0]      core_iszero,
    input  logic [LANES-1:0]      core_overflow
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [AW:0] LANES_V = (AW+1)'(LANES);

    state_t state, next_state;

    logic [2:0]  cmd_q;
    logic [AW:0] len_q;
    logic [AW:0] base;
    logic [AW:0] len_clamped;
    logic [AW:0] lane_idx [LANES];
    logic [LANES-1:0] lane_act;
    logic        last_chunk;

    logic [31:0] buf_a [DEPTH];
    logic [31:0] buf_b [DEPTH];
    logic [31:0] buf_r [DEPTH];

    // base is the element index of the current chunk's lane 0
    always_comb begin
        len_clamped = (len > DEPTH_V) ? DEPTH_V : len;
        last_chunk  = ((base + LANES_V) >= len_q);
        lane_act    = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_idx[i] = base + (AW+1)'(i);
            lane_act[i] = (lane_idx[i] < len_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = (len == '0) ? DONE : ISSUE;
            end
            ISSUE:   next_state = CAPTURE;
            CAPTURE: next_state = last_chunk ? DONE : ISSUE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q        <= '0;
            len_q        <= '0;
            base         <= '0;
            core_command <= '0;
            core_opA     <= '0;
            core_opB     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cmd_q <= cmd;
                        len_q <= len_clamped;
                        base  <= '0;
                    end
                end
                ISSUE: begin
                    core_command <= cmd_q;
                    for (int i = 0; i < LANES; i++) begin
                        core_opA[32*i +: 32] <= buf_a[lane_idx[i][AW-1:0]];
                        core_opB[32*i +: 32] <= buf_b[lane_idx[i][AW-1:0]];
                    end
                end
                CAPTURE: base <= base + LANES_V;
                default: ;
            endcase
        end
    end

    // Buffers are deliberately not reset; contents survive a reset
    always_ff @(posedge clk) begin
        if (state == IDLE && wr_en) begin
            if (wr_sel) buf_b[wr_addr] <= wr_data;
            else        buf_a[wr_addr] <= wr_data;
        end
        if (state == CAPTURE) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_act[i]) buf_r[lane_idx[i][AW-1:0]] <= core_result[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rd_data <= '0;
        else       rd_data <= buf_r[rd_addr];
    end

`ifdef SIMD_SEQ_FLAGS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            any_overflow <= 1'b0;
            all_zero     <= 1'b0;
        end else if (state == IDLE && start) begin
            any_overflow <= 1'b0;
            all_zero     <= 1'b1;
        end else if (state == CAPTURE) begin
            any_overflow <= any_overflow | (|(core_overflow & lane_act));
            all_zero     <= all_zero & (&(core_iszero | ~lane_act));
        end
    end
`else
    logic unused_flags;
    assign unused_flags = ^{core_iszero, core_overflow};
    assign any_overflow = 1'b0;
    assign all_zero     = 1'b0;
`endif

endmodule

// File: tb/tb_simd_sequencer.sv
// Randomised scoreboard bench for simd_sequencer with a behavioural simdcore and element-level reference model.
module tb_simd_sequencer;
    localparam int LANES = 16;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
`ifdef SIMD_SEQ_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset, wr_en, wr_sel, start;
    logic [AW-1:0]       wr_addr, rd_addr;
    logic [31:0]         wr_data, rd_data;
    logic [2:0]          cmd, core_command;
    logic [AW:0]         len;
    logic                busy, done, any_overflow, all_zero;
    logic [32*LANES-1:0] core_opA, core_opB, core_result;
    logic [LANES-1:0]    core_iszero, core_overflow;

    simd_sequencer #(.LANES(LANES), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .cmd(cmd), .len(len), .busy(busy), .done(done),
        .any_overflow(any_overflow), .all_zero(all_zero), .rd_addr(rd_addr), .rd_data(rd_data),
        .core_command(core_command), .core_opA(core_opA), .core_opB(core_opB),
        .core_result(core_result), .core_iszero(core_iszero), .core_overflow(core_overflow)
    );

    // Returns {signed_overflow, result}
    function automatic logic [32:0] alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        v;
        v = 1'b0;
        case (c)
            3'd0: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            3'd1: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            3'd2: r = a ^ b;
            3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: r = a & b;
            3'd5: r = ~(a & b);
            3'd6: r = ~(a | b);
            default: r = a | b;
        endcase
        return {v, r};
    endfunction

    always_comb begin
        logic [32:0] t;
        t             = '0;
        core_result   = '0;
        core_iszero   = '0;
        core_overflow = '0;
        for (int i = 0; i < LANES; i++) begin
            t = alu(core_command, core_opA[32*i +: 32], core_opB[32*i +: 32]);
            core_result[32*i +: 32] = t[31:0];
            core_overflow[i]        = t[32];
            core_iszero[i]          = (t[31:0] == 32'd0);
        end
    end

    typedef struct {
        int   cyc;
        logic any;
        logic all;
    } done_exp_t;

    done_exp_t   done_q[$];
    logic [31:0] rd_q[$];

    logic [31:0] ref_a [DEPTH];
    logic [31:0] ref_b [DEPTH];
    logic [31:0] ref_r [DEPTH];
    bit          ref_known [DEPTH];
    logic [32*LANES-1:0] exp_opa, exp_opb;
    logic [2:0]  exp_cmd;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    logic rd_req;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_w(input string name, input logic [32*LANES-1:0] act, input logic [32*LANES-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents read data or a done pulse
    always @(posedge clk) begin : monitor
        logic      rq;
        done_exp_t e;
        rq = rd_req;
        #1;
        if (rq) begin
            if (rd_q.size() == 0) chk("rd_queue_underflow", 64'd1, 64'd0);
            else chk("rd_data", {32'd0, rd_data}, {32'd0, rd_q.pop_front()});
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = done_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("busy_at_done", {63'd0, busy}, 64'd1);
                chk("any_overflow", {63'd0, any_overflow}, {63'd0, e.any});
                chk("all_zero", {63'd0, all_zero}, {63'd0, e.all});
            end
        end
    end

    task automatic wr(input bit sel, input int a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(a); wr_data = d;
        if (sel) ref_b[a] = d; else ref_a[a] = d;
        @(posedge clk); #1 wr_en = 1'b0;
    endtask

    task automatic rd(input int a);
        @(negedge clk);
        rd_addr = AW'(a); rd_req = 1'b1;
        rd_q.push_back(ref_r[a]);
        @(posedge clk); #1 rd_req = 1'b0;
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) if (ref_known[a]) rd(a);
    endtask

    // mode 0: plain job, 1: start+write poked at cycle 2, 2: reset at cycle 3
    task automatic run_job(input logic [2:0] c, input int l, input int mode);
        int lc, nc, s, lim;
        logic any, all;
        logic [32:0] t;
        done_exp_t e;
        @(negedge clk);
        start = 1'b1; cmd = c; len = (AW+1)'(l); s = cyc;
        lc  = (l > DEPTH) ? DEPTH : l;
        nc  = (lc + LANES - 1) / LANES;
        any = 1'b0; all = 1'b1;
        if (nc > 0) begin
            for (int i = 0; i < LANES; i++) begin
                exp_opa[32*i +: 32] = ref_a[(nc-1)*LANES + i];
                exp_opb[32*i +: 32] = ref_b[(nc-1)*LANES + i];
            end
            exp_cmd = c;
        end
        lim = (mode == 2) ? ((lc < LANES) ? lc : LANES) : lc;
        for (int i = 0; i < lc; i++) begin
            t   = alu(c, ref_a[i], ref_b[i]);
            any = any | t[32];
            all = all & (t[31:0] == 32'd0);
            if (i < lim) begin ref_r[i] = t[31:0]; ref_known[i] = 1'b1; end
        end
        if (mode != 2) begin
            e.cyc = s + 2*nc + 1; e.any = FLAGS_EN & any; e.all = FLAGS_EN & all;
            done_q.push_back(e);
        end
        @(posedge clk); #1 start = 1'b0;
        chk("busy_cycle1", {63'd0, busy}, 64'd1);
        if (mode == 1) begin
            @(negedge clk);
            start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 32'h0000FFFF;
            @(posedge clk); #1 start = 1'b0; wr_en = 1'b0;
        end
        if (mode == 2) begin
            @(negedge clk); @(negedge clk);
            reset = 1'b1;
            @(posedge clk); #1 reset = 1'b0;
            chk("rst_busy_c4", {63'd0, busy}, 64'd0);
            chk("rst_done_c4", {63'd0, done}, 64'd0);
            @(posedge clk); #1;
            chk("rst_busy_c5", {63'd0, busy}, 64'd0);
            chk("rst_done_c5", {63'd0, done}, 64'd0);
            chk("rst_flags", {62'd0, any_overflow, all_zero}, 64'd0);
            exp_opa = '0; exp_opb = '0; exp_cmd = '0;
        end else begin
            repeat (2*nc + 3) @(posedge clk);
            #1;
            chk("done_seen", 64'(done_q.size()), 64'd0);
            done_q.delete();
            chk("busy_after_done", {63'd0, busy}, 64'd0);
        end
        chk_w("core_opA", core_opA, exp_opa);
        chk_w("core_opB", core_opB, exp_opb);
        chk("core_command", {61'd0, core_command}, {61'd0, exp_cmd});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; cmd = '0; len = '0; rd_addr = '0; rd_req = 1'b0;
        exp_opa = '0; exp_opb = '0; exp_cmd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_a[i] = 'x; ref_b[i] = 'x; ref_r[i] = 'x; ref_known[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_flags", {62'd0, any_overflow, all_zero}, 64'd0);
        chk("rst_rd_data", {32'd0, rd_data}, 64'd0);
        chk_w("rst_opA", core_opA, '0);
        chk_w("rst_opB", core_opB, '0);
        chk("rst_command", {61'd0, core_command}, 64'd0);

        // single chunk
        for (int i = 0; i < DEPTH; i++) begin wr(0, i, 32'(i)); wr(1, i, 32'd100); end
        run_job(3'd0, 16, 0);
        read_all();

        // partial last chunk over a 0xDEAD background
        for (int i = 0; i < DEPTH; i++) begin wr(0, i, 32'hDEAD); wr(1, i, 32'd0); end
        run_job(3'd0, 64, 0);
        for (int i = 0; i < DEPTH; i++) begin wr(0, i, 32'd1); wr(1, i, 32'd1); end
        run_job(3'd0, 40, 0);
        read_all();

        // flag masking
        wr(0, 5, 32'h7FFFFFFF);
        run_job(3'd0, 6, 0);
        run_job(3'd0, 5, 0);
        wr(0, 5, 32'd1);
        run_job(3'd1, 8, 0);

        // zero length leaves operands and results alone
        run_job(3'd2, 0, 0);
        read_all();

        // start/write while busy are ignored
        run_job(3'd0, 32, 1);
        run_job(3'd0, 1, 0);
        read_all();

        // reset mid-job, then a normal job
        for (int i = 0; i < DEPTH; i++) wr(0, i, 32'(i * 3));
        run_job(3'd4, 64, 2);
        read_all();
        run_job(3'd7, 50, 0);
        read_all();

        // randomised jobs, including len above DEPTH
        for (int n = 0; n < 8; n++) begin
            for (int w = 0; w < 12; w++)
                wr(bit'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)),
                   ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom);
            run_job(3'($urandom_range(0, 7)), int'($urandom_range(0, 80)), 0);
            read_all();
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
